// File: rtl/icache_dm_line.sv
// -----------------------------------------------------------------------------
// icache_dm_line
//
// Direct-mapped instruction cache with multi-word lines. It sits between the
// fetch stage and main memory. A hit returns the addressed instruction on the
// clock edge after the request. A miss stalls fetch while the cache refills
// the whole line in order, one word per accepted beat. It then installs the
// line and returns the requested word.
//
// Parameters:
//   INDEX_W  number of index bits; the cache holds 2**INDEX_W lines
//   WORDS    32-bit words per line (power of two, >= 2)
//   NOP      instruction driven whenever no valid instruction is returned
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   req_valid    fetch request present this cycle
//   address      byte address of the fetch (bits [1:0] ignored)
//   flush        invalidate every line, abort any refill
//   instr        returned instruction (registered)
//   instr_valid  instr is valid this cycle (registered)
//   stall        combinational, fetch must hold the PC
//   mem_req      refill beat request (registered)
//   mem_addr     word-aligned address of the current beat (registered)
//   mem_ready    mem_data carries the current beat
//   mem_data     refill data
//   hit_count    lookups that hit, saturating    (only with ICACHE_STATS_EN)
//   miss_count   lookups that missed, saturating (only with ICACHE_STATS_EN)
//
// Optional feature macro: ICACHE_STATS_EN adds the hit/miss counters.
// -----------------------------------------------------------------------------
module icache_dm_line #(
    parameter int          INDEX_W = 8,
    parameter int          WORDS   = 4,
    parameter logic [31:0] NOP     = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] address,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - OFF_W - INDEX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    typedef enum logic {
        S_IDLE,
        S_REFILL
    } state_t;

    state_t state;
    state_t state_next;

    // Storage: the data array is addressed by {index, word offset}.
    logic [31:0]      data_mem [LINES*WORDS];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid_bits;

    // Request address fields
    logic [OFF_W-1:0]         req_off;
    logic [INDEX_W-1:0]       req_index;
    logic [TAG_W-1:0]         req_tag;
    logic [INDEX_W+OFF_W-1:0] rd_sel;
    logic                     lookup_hit;
    logic                     addr_lsb_unused;

    // Latched miss context
    logic [TAG_W-1:0]   miss_tag;
    logic [INDEX_W-1:0] miss_index;
    logic [OFF_W-1:0]   miss_offset;
    logic [OFF_W-1:0]   beat;

    // Control decoded from the current state
    logic        lookup;
    logic        start_refill;
    logic        beat_accept;
    logic        last_beat;
    logic [31:0] fill_word;

    assign req_off         = address[OFF_W+1:2];
    assign req_index       = address[OFF_W+INDEX_W+1:OFF_W+2];
    assign req_tag         = address[31:OFF_W+INDEX_W+2];
    assign rd_sel          = {req_index, req_off};
    assign addr_lsb_unused = ^address[1:0];

    assign lookup_hit = valid_bits[req_index] && (tag_mem[req_index] == req_tag);

    // The word returned at the end of a refill. If it is the word arriving on
    // this final beat, it is not in the array yet, so it comes from mem_data.
    assign fill_word = (miss_offset == beat) ? mem_data
                                             : data_mem[{miss_index, miss_offset}];

    // Next-state and control decode. flush wins over everything in the
    // datapath except rst. A flushed cycle therefore neither looks up nor
    // accepts a beat, and it does not stall fetch.
    always_comb begin
        state_next   = state;
        lookup       = 1'b0;
        start_refill = 1'b0;
        beat_accept  = 1'b0;
        last_beat    = 1'b0;
        stall        = 1'b0;
        if (flush) begin
            state_next = S_IDLE;
        end else if (state == S_IDLE) begin
            if (req_valid) begin
                lookup = 1'b1;
                if (!lookup_hit) begin
                    start_refill = 1'b1;
                    stall        = 1'b1;
                    state_next   = S_REFILL;
                end
            end
        end else begin
            stall = 1'b1;
            if (mem_req && mem_ready) begin
                beat_accept = 1'b1;
                if (beat == LAST_BEAT) begin
                    last_beat  = 1'b1;
                    state_next = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Valid bits are flops so that flush can clear them all in one cycle.
    // A line being replaced is invalidated when its refill starts. An aborted
    // refill therefore never leaves a stale tag paired with partly new data.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_bits <= '0;
        end else if (start_refill) begin
            valid_bits[req_index] <= 1'b0;
        end else if (last_beat) begin
            valid_bits[miss_index] <= 1'b1;
        end
    end

    // Data and tag arrays are not reset.
    always_ff @(posedge clk) begin
        if (!rst && beat_accept) begin
            data_mem[{miss_index, beat}] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && last_beat) begin
            tag_mem[miss_index] <= miss_tag;
        end
    end

    // Output, refill-address and miss-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            beat        <= '0;
            miss_tag    <= '0;
            miss_index  <= '0;
            miss_offset <= '0;
        end else if (flush) begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
        end else begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            if (lookup && lookup_hit) begin
                instr       <= data_mem[rd_sel];
                instr_valid <= 1'b1;
            end
            if (start_refill) begin
                miss_tag    <= req_tag;
                miss_index  <= req_index;
                miss_offset <= req_off;
                beat        <= '0;
                mem_req     <= 1'b1;
                mem_addr    <= {req_tag, req_index, {OFF_W{1'b0}}, 2'b00};
            end
            if (beat_accept) begin
                beat     <= beat + OFF_W'(1);
                mem_addr <= mem_addr + 32'd4;
                if (last_beat) begin
                    mem_req     <= 1'b0;
                    instr       <= fill_word;
                    instr_valid <= 1'b1;
                end
            end
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating lookup statistics. Only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (lookup) begin
            if (lookup_hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else begin
                if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm_line.sv
module tb_icache_dm_line;

    localparam int          INDEX_W    = 8;
    localparam int          WORDS      = 4;
    localparam logic [31:0] NOP        = 32'h00000013;
    localparam int          LINE_BYTES = WORDS * 4;
    localparam int          LINES      = 1 << INDEX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] address;
    logic        flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icache_dm_line #(.INDEX_W(INDEX_W), .WORDS(WORDS), .NOP(NOP)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .address(address),
        .flush(flush),
        .instr(instr),
        .instr_valid(instr_valid),
        .stall(stall),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_data(mem_data)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    // Behavioural model: a flat memory image plus a per-line {valid, tag} map
    logic [31:0] mem_img     [int unsigned];
    bit          model_valid [int unsigned];
    int unsigned model_tag   [int unsigned];
    logic [31:0] addr_trace  [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int unsigned k;
        k = a & 32'hFFFF_FFFC;
        if (!mem_img.exists(k)) mem_img[k] = $urandom;
        return mem_img[k];
    endfunction

    function automatic bit model_hits(input logic [31:0] a);
        int unsigned line;
        int unsigned idx;
        int unsigned tg;
        line = a / LINE_BYTES;
        idx  = line % LINES;
        tg   = line / LINES;
        return model_valid.exists(idx) && model_valid[idx] && (model_tag[idx] == tg);
    endfunction

    function automatic void model_fill(input logic [31:0] a);
        int unsigned line;
        line = a / LINE_BYTES;
        model_valid[line % LINES] = 1'b1;
        model_tag[line % LINES]   = line / LINES;
    endfunction

    function automatic void model_clear();
        model_valid.delete();
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        address = '0; mem_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // Issue one fetch and act as memory until instr_valid appears (bounded).
    // mode 0: mem_ready always high, 1: toggling 1,0,1,..., 2: random
    task automatic run_fetch(input logic [31:0] a, input int mode,
                             output logic [31:0] got_instr, output bit got_valid,
                             output bit saw_stall, output int lat, output int stall_lows);
        int  phase;
        logic rdy;
        address = a; req_valid = 1'b1; mem_ready = 1'b0;
        #1;
        saw_stall = stall;
        @(posedge clk); #1;
        req_valid = 1'b0;
        address = $urandom;
        lat = 1; stall_lows = 0; phase = 0;
        addr_trace.delete();
        while (!instr_valid && lat < 200) begin
            if (!stall) stall_lows++;
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (phase % 2 == 0);
            else rdy = 1'($urandom_range(0, 1));
            phase++;
            addr_trace.push_back(mem_addr);
            mem_ready = rdy;
            mem_data  = rdy ? mem_word(mem_addr) : $urandom;
            @(posedge clk); #1;
            lat++;
        end
        mem_ready = 1'b0;
        got_valid = instr_valid;
        got_instr = instr;
        model_fill(a);
    endtask

    task automatic test_reset();
        logic [31:0] gi; bit gv, ss; int lat, sl;
        do_reset();
        checks++; if (instr !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h expected %h", instr, NOP); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        run_fetch(32'h0, 0, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b1) begin errors++; $display("[TB] FAIL reset_first_miss: stall got %b expected 1", ss); end
        checks++; if (!gv || gi !== mem_word(32'h0)) begin errors++; $display("[TB] FAIL reset_first_data: got %h/%b expected %h/1", gi, gv, mem_word(32'h0)); end
    endtask

    task automatic test_cold_miss_then_hit();
        logic [31:0] gi; bit gv, ss; int lat, sl;
        for (int i = 0; i < WORDS; i++) mem_img[32'h1000 + 4*i] = 32'hA0 + i;
        run_fetch(32'h0000_1008, 0, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b1) begin errors++; $display("[TB] FAIL cold_miss_stall: got %b expected 1", ss); end
        checks++; if (lat != WORDS + 1) begin errors++; $display("[TB] FAIL cold_miss_latency: got %0d expected %0d", lat, WORDS + 1); end
        checks++; if (!gv || gi !== 32'hA2) begin errors++; $display("[TB] FAIL cold_miss_data: got %h/%b expected 000000a2/1", gi, gv); end
        checks++; if (sl != 0) begin errors++; $display("[TB] FAIL cold_miss_stall_held: low cycles got %0d expected 0", sl); end
        checks++; if (addr_trace.size() != WORDS) begin errors++; $display("[TB] FAIL cold_miss_beats: got %0d expected %0d", addr_trace.size(), WORDS); end
        for (int i = 0; i < addr_trace.size() && i < WORDS; i++) begin
            checks++;
            if (addr_trace[i] !== 32'h1000 + 4*i) begin errors++; $display("[TB] FAIL cold_miss_beat_addr%0d: got %h expected %h", i, addr_trace[i], 32'h1000 + 4*i); end
        end
        // back-to-back request right after the refill completes
        run_fetch(32'h0000_100C, 0, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b0) begin errors++; $display("[TB] FAIL hit_stall: got %b expected 0", ss); end
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL hit_latency: got %0d expected 1", lat); end
        checks++; if (!gv || gi !== 32'hA3) begin errors++; $display("[TB] FAIL hit_data: got %h/%b expected 000000a3/1", gi, gv); end
    endtask

    task automatic test_conflict();
        logic [31:0] gi; bit gv, ss; int lat, sl;
        run_fetch(32'h0000_1000, 0, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b0 || gi !== 32'hA0) begin errors++; $display("[TB] FAIL conflict_prefill: stall/data got %b/%h expected 0/000000a0", ss, gi); end
        run_fetch(32'h0000_5000, 0, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b1 || lat != WORDS + 1) begin errors++; $display("[TB] FAIL conflict_miss: stall/lat got %b/%0d expected 1/%0d", ss, lat, WORDS + 1); end
        checks++; if (!gv || gi !== mem_word(32'h5000)) begin errors++; $display("[TB] FAIL conflict_data: got %h expected %h", gi, mem_word(32'h5000)); end
        run_fetch(32'h0000_1000, 0, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b1) begin errors++; $display("[TB] FAIL conflict_evicted: stall got %b expected 1", ss); end
        checks++; if (!gv || gi !== 32'hA0) begin errors++; $display("[TB] FAIL conflict_refetch: got %h expected 000000a0", gi); end
    endtask

    task automatic test_ready_toggle();
        logic [31:0] gi; bit gv, ss; int lat, sl;
        logic [31:0] base, exp_a;
        base = 32'h0000_2000;
        run_fetch(base + 32'h4, 1, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b1) begin errors++; $display("[TB] FAIL toggle_miss: stall got %b expected 1", ss); end
        checks++; if (sl != 0) begin errors++; $display("[TB] FAIL toggle_stall_held: low cycles got %0d expected 0", sl); end
        checks++; if (lat - 1 != 2*WORDS - 1) begin errors++; $display("[TB] FAIL toggle_refill_cycles: got %0d expected %0d", lat - 1, 2*WORDS - 1); end
        checks++; if (!gv || gi !== mem_word(base + 32'h4)) begin errors++; $display("[TB] FAIL toggle_data: got %h expected %h", gi, mem_word(base + 32'h4)); end
        for (int i = 0; i < addr_trace.size(); i++) begin
            exp_a = base + 32'(4 * ((i + 1) / 2));
            checks++;
            if (addr_trace[i] !== exp_a) begin errors++; $display("[TB] FAIL toggle_mem_addr%0d: got %h expected %h", i, addr_trace[i], exp_a); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] gi; bit gv, ss; int lat, sl, iv;
        logic [31:0] a;
        a = 32'h0000_3008;
        address = a; req_valid = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL flush_setup_miss: stall got %b expected 1", stall); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_ready = 1'b1; mem_data = mem_word(mem_addr);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1; mem_data = mem_word(mem_addr); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; mem_ready = 1'b0;
        model_clear();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL flush_mem_req: got %b expected 0", mem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_instr_valid: got %b expected 0", instr_valid); end
        iv = 0;
        repeat (4) begin
            mem_ready = 1'b1; mem_data = $urandom;
            @(posedge clk); #1;
            if (instr_valid || stall) iv++;
        end
        mem_ready = 1'b0;
        checks++; if (iv != 0) begin errors++; $display("[TB] FAIL flush_quiet: active cycles got %0d expected 0", iv); end
        run_fetch(a, 0, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b1) begin errors++; $display("[TB] FAIL flush_refetch_miss: stall got %b expected 1", ss); end
        checks++; if (!gv || gi !== mem_word(a)) begin errors++; $display("[TB] FAIL flush_refetch_data: got %h expected %h", gi, mem_word(a)); end
        // flush together with a request in IDLE
        address = a; req_valid = 1'b1; flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        model_clear();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_unserviced: got %b expected 0", instr_valid); end
        run_fetch(a, 0, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b1) begin errors++; $display("[TB] FAIL flush_idle_invalidated: stall got %b expected 1", ss); end
    endtask

    task automatic test_reset_midrefill();
        logic [31:0] gi; bit gv, ss; int lat, sl;
        logic [31:0] a;
        a = 32'h0000_4000;
        address = a; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_ready = 1'b1; mem_data = mem_word(mem_addr);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        model_clear();
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_mem: req/addr got %b/%h expected 0/00000000", mem_req, mem_addr); end
        checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("[TB] FAIL rst_mid_instr: got %h/%b expected %h/0", instr, instr_valid, NOP); end
        run_fetch(a, 0, gi, gv, ss, lat, sl);
        checks++; if (ss !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_line_invalid: stall got %b expected 1", ss); end
        checks++; if (!gv || gi !== mem_word(a)) begin errors++; $display("[TB] FAIL rst_mid_refetch: got %h expected %h", gi, mem_word(a)); end
    endtask

    task automatic test_random();
        logic [31:0] gi; bit gv, ss; int lat, sl, mode, exp_lat;
        logic [31:0] a;
        bit exp_miss;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                model_clear();
            end
            a = 32'($urandom_range(0, 2)) * LINES * LINE_BYTES
              + 32'($urandom_range(0, 3)) * LINE_BYTES
              + 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(0, 3));
            mode = $urandom_range(0, 2);
            exp_miss = !model_hits(a);
            run_fetch(a, mode, gi, gv, ss, lat, sl);
            checks++; if (ss !== exp_miss) begin errors++; $display("[TB] FAIL rand_hitmiss[%0d] addr %h: stall got %b expected %b", n, a, ss, exp_miss); end
            checks++; if (!gv || gi !== mem_word(a)) begin errors++; $display("[TB] FAIL rand_data[%0d] addr %h: got %h/%b expected %h/1", n, a, gi, gv, mem_word(a)); end
            if (mode != 2) begin
                exp_lat = !exp_miss ? 1 : (mode == 0 ? WORDS + 1 : 2*WORDS);
                checks++; if (lat != exp_lat) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, exp_lat); end
            end
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] gi; bit gv, ss; int lat, sl;
        do_reset();
        for (int i = 1; i <= 3; i++) run_fetch(32'(i * 32'h100), 0, gi, gv, ss, lat, sl);
        for (int i = 0; i < 5; i++) run_fetch(32'((i % 3 + 1) * 32'h100 + 4 * (i % WORDS)), 0, gi, gv, ss, lat, sl);
        checks++; if (miss_count !== 32'd3) begin errors++; $display("[TB] FAIL stats_miss: got %0d expected 3", miss_count); end
        checks++; if (hit_count !== 32'd5) begin errors++; $display("[TB] FAIL stats_hit: got %0d expected 5", hit_count); end
        address = 32'h100; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        model_clear();
        checks++; if (miss_count !== 32'd3 || hit_count !== 32'd5) begin errors++; $display("[TB] FAIL stats_flush: got %0d/%0d expected 3/5", miss_count, hit_count); end
    endtask
`endif

    initial begin
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        address = '0; mem_data = '0;
        test_reset();
        test_cold_miss_then_hit();
        test_conflict();
        test_ready_toggle();
        test_flush();
        test_reset_midrefill();
        test_random();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
